// File: rtl/mul_div_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : mul_div_unit
//  Purpose  : Iterative signed multiply (radix-2 Booth) / divide (restoring)
//             unit producing a 2*DATA_WIDTH result as Z_HI/Z_LO.
//  Options  : MULDIV_DIV_EN - when defined, the divide datapath, the FIX
//             state and div_by_zero are present. When undefined, op=1
//             completes in one cycle with a zero result.
//  Revision : 1.0 - initial release
// ============================================================================
module mul_div_unit #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clock,
    input  logic                  clear,
    input  logic                  start,
    input  logic                  op,
    input  logic [DATA_WIDTH-1:0] A,
    input  logic [DATA_WIDTH-1:0] B,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] Z_HI,
    output logic [DATA_WIDTH-1:0] Z_LO,
    output logic                  div_by_zero
);

    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(DATA_WIDTH);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_MUL  = 3'd1,
        S_DIV  = 3'd2,
        S_FIX  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [W:0]     acc_q, acc_d;     // Booth accumulator / partial remainder
    logic [W-1:0]   q_q, q_d;         // multiplier Q / dividend-quotient shifter
    logic           qm1_q, qm1_d;     // Booth q-1 bit
    logic [W-1:0]   m_q, m_d;         // multiplicand / |divisor|
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic [W-1:0]   zhi_q, zhi_d;
    logic [W-1:0]   zlo_q, zlo_d;

    logic [W:0]     w_sum;
    logic [W:0]     w_acc_sh;
    logic [W-1:0]   w_q_sh;
    logic           w_last;

`ifdef MULDIV_DIV_EN
    logic [W-1:0]   a_q, a_d;         // original dividend, returned on B==0
    logic           sa_q, sa_d;       // sign of dividend
    logic           sb_q, sb_d;       // sign of divisor
    logic           dbz_q, dbz_d;
    logic [W:0]     w_rem_sh;
    logic [W:0]     w_diff;
`endif

    // State and datapath registers, cleared asynchronously
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            q_q     <= '0;
            qm1_q   <= 1'b0;
            m_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            zhi_q   <= '0;
            zlo_q   <= '0;
`ifdef MULDIV_DIV_EN
            a_q     <= '0;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            dbz_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            q_q     <= q_d;
            qm1_q   <= qm1_d;
            m_q     <= m_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            zhi_q   <= zhi_d;
            zlo_q   <= zlo_d;
`ifdef MULDIV_DIV_EN
            a_q     <= a_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            dbz_q   <= dbz_d;
`endif
        end
    end

    // Next-state, iteration datapath and result capture
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        q_d     = q_q;
        qm1_d   = qm1_q;
        m_d     = m_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        zhi_d   = zhi_q;
        zlo_d   = zlo_q;
        w_last  = (cnt_q == CW'(W - 1));

        // Booth step: add/subtract sign-extended multiplicand, then an
        // arithmetic shift right of {acc, Q, q-1}. The extra accumulator
        // bit keeps MIN*MIN exact.
        w_sum = acc_q;
        case ({q_q[0], qm1_q})
            2'b01:   w_sum = acc_q + {m_q[W-1], m_q};
            2'b10:   w_sum = acc_q - {m_q[W-1], m_q};
            default: w_sum = acc_q;
        endcase
        w_acc_sh = {w_sum[W], w_sum[W:1]};
        w_q_sh   = {w_sum[0], q_q[W-1:1]};

`ifdef MULDIV_DIV_EN
        a_d   = a_q;
        sa_d  = sa_q;
        sb_d  = sb_q;
        dbz_d = dbz_q;
        // Restoring step: shift next dividend bit into the remainder and
        // subtract the divisor when it fits (no borrow out of bit W).
        w_rem_sh = {acc_q[W-1:0], q_q[W-1]};
        w_diff   = w_rem_sh - {1'b0, m_q};
`endif

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    busy_d = 1'b1;
                    cnt_d  = '0;
                    acc_d  = '0;
                    qm1_d  = 1'b0;
`ifdef MULDIV_DIV_EN
                    dbz_d  = 1'b0;
`endif
                    if (!op) begin
                        state_d = S_MUL;
                        q_d     = B;
                        m_d     = A;
                    end else begin
                        state_d = S_DIV;
`ifdef MULDIV_DIV_EN
                        q_d  = A[W-1] ? (~A + 1'b1) : A;
                        m_d  = B[W-1] ? (~B + 1'b1) : B;
                        a_d  = A;
                        sa_d = A[W-1];
                        sb_d = B[W-1];
`endif
                    end
                end
            end
            S_MUL: begin
                acc_d = w_acc_sh;
                q_d   = w_q_sh;
                qm1_d = q_q[0];
                cnt_d = cnt_q + 1'b1;
                if (w_last) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    zhi_d   = w_acc_sh[W-1:0];
                    zlo_d   = w_q_sh;
                end
            end
            S_DIV: begin
`ifdef MULDIV_DIV_EN
                if (m_q == '0) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    zlo_d   = '1;
                    zhi_d   = a_q;
                    dbz_d   = 1'b1;
                end else begin
                    acc_d = w_diff[W] ? w_rem_sh : w_diff;
                    q_d   = {q_q[W-2:0], ~w_diff[W]};
                    cnt_d = cnt_q + 1'b1;
                    if (w_last) begin
                        state_d = S_FIX;
                    end
                end
`else
                state_d = S_DONE;
                done_d  = 1'b1;
                zhi_d   = '0;
                zlo_d   = '0;
`endif
            end
`ifdef MULDIV_DIV_EN
            S_FIX: begin
                // Truncating division: quotient sign is the XOR of operand
                // signs, remainder follows the dividend.
                state_d = S_DONE;
                done_d  = 1'b1;
                zlo_d   = (sa_q ^ sb_q) ? (~q_q + 1'b1) : q_q;
                zhi_d   = sa_q ? (~acc_q[W-1:0] + 1'b1) : acc_q[W-1:0];
            end
`endif
            S_DONE: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign busy = busy_q;
    assign done = done_q;
    assign Z_HI = zhi_q;
    assign Z_LO = zlo_q;
`ifdef MULDIV_DIV_EN
    assign div_by_zero = dbz_q;
`else
    assign div_by_zero = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mul_div_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_mul_div_unit
//  Purpose  : Directed self-checking bench for mul_div_unit with a result
//             scoreboard filled at issue and drained at each done pulse.
//             Follows MULDIV_DIV_EN for the divide expectations.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mul_div_unit;

    localparam int W = 32;
    localparam logic [W-1:0] MIN = {1'b1, {(W-1){1'b0}}};

    typedef struct packed {
        logic [W-1:0] zhi;
        logic [W-1:0] zlo;
        logic         dbz;
        logic [7:0]   lat;
    } exp_t;

    logic         clock = 1'b0;
    logic         clear = 1'b1;
    logic         start = 1'b0;
    logic         op    = 1'b0;
    logic [W-1:0] A     = '0;
    logic [W-1:0] B     = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] Z_HI;
    logic [W-1:0] Z_LO;
    logic         div_by_zero;

    int   n_vec = 0;
    int   n_err = 0;
    exp_t sb[$];
    logic [W-1:0] prev_hi = '0;
    logic [W-1:0] prev_lo = '0;

    mul_div_unit #(.DATA_WIDTH(W)) dut (
        .clock       (clock),
        .clear       (clear),
        .start       (start),
        .op          (op),
        .A           (A),
        .B           (B),
        .busy        (busy),
        .done        (done),
        .Z_HI        (Z_HI),
        .Z_LO        (Z_LO),
        .div_by_zero (div_by_zero)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference result and completion edge from language arithmetic
    function automatic exp_t model(input logic o, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t r;
        logic signed [2*W-1:0] p;
        logic signed [W-1:0]   sa, sb2, qq, rr;
        r = '0;
        if (!o) begin
            p     = $signed({{W{a[W-1]}}, a}) * $signed({{W{b[W-1]}}, b});
            r.zhi = p[2*W-1:W];
            r.zlo = p[W-1:0];
            r.lat = 8'(W);
        end else begin
`ifdef MULDIV_DIV_EN
            if (b == '0) begin
                r.zhi = a;
                r.zlo = '1;
                r.dbz = 1'b1;
                r.lat = 8'd1;
            end else if (a == MIN && b == '1) begin
                r.zhi = '0;
                r.zlo = MIN;
                r.lat = 8'(W + 1);
            end else begin
                sa    = a;
                sb2   = b;
                qq    = sa / sb2;
                rr    = sa % sb2;
                r.zhi = rr;
                r.zlo = qq;
                r.lat = 8'(W + 1);
            end
`else
            r.lat = 8'd1;
`endif
        end
        return r;
    endfunction

    // Issue one operation and follow it to completion (bounded)
    task automatic run_op(input logic o, input logic [W-1:0] a, input logic [W-1:0] b,
                          input int pulse_at, input bit b2b);
        exp_t ex, got;
        int   ndone;
        ex    = model(o, a, b);
        sb.push_back(ex);
        ndone = 0;
        @(negedge clock);
        start = 1'b1; op = o; A = a; B = b;
        @(posedge clock); #1;
        start = 1'b0; op = 1'($urandom); A = $urandom; B = $urandom;
        chk("busy_after_accept", 64'(busy), 64'd1);
        for (int e = 1; e <= int'(ex.lat) + 1; e++) begin
            start = (e == pulse_at) || (b2b && e == int'(ex.lat) + 1);
            @(posedge clock); #1;
            if (e == 5 && int'(ex.lat) > 5) begin
                chk("hold_prev_hi", 64'(Z_HI), 64'(prev_hi));
                chk("hold_prev_lo", 64'(Z_LO), 64'(prev_lo));
            end
            if (done) begin
                ndone++;
                if (ndone == 1) begin
                    chk("done_edge", 64'(e), 64'(ex.lat));
                    got = sb.pop_front();
                    chk("z_hi", 64'(Z_HI), 64'(got.zhi));
                    chk("z_lo", 64'(Z_LO), 64'(got.zlo));
                    chk("div_by_zero", 64'(div_by_zero), 64'(got.dbz));
                    prev_hi = got.zhi;
                    prev_lo = got.zlo;
                end
            end
            if (e == int'(ex.lat))
                chk("busy_in_done", 64'(busy), 64'd1);
            if (e == int'(ex.lat) + 1)
                chk("busy_after_done", 64'(busy), 64'd0);
        end
        chk("done_pulse_count", 64'(ndone), 64'd1);
        if (ndone == 0 && sb.size() > 0)
            void'(sb.pop_front());
        if (!b2b)
            start = 1'b0;
    endtask

    initial begin
        int nd;
        // reset state
        repeat (2) @(posedge clock);
        #1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_zhi", 64'(Z_HI), 64'd0);
        chk("rst_zlo", 64'(Z_LO), 64'd0);
        chk("rst_dbz", 64'(div_by_zero), 64'd0);
        @(negedge clock);
        clear = 1'b0;

        // multiplies
        run_op(1'b0, 32'd7, 32'hFFFF_FFFD, 0, 1'b0);
        chk("mul_7x-3_hi", 64'(Z_HI), 64'hFFFF_FFFF);
        chk("mul_7x-3_lo", 64'(Z_LO), 64'hFFFF_FFEB);
        run_op(1'b0, MIN, MIN, 0, 1'b0);
        chk("mul_minxmin_hi", 64'(Z_HI), 64'h4000_0000);
        chk("mul_minxmin_lo", 64'(Z_LO), 64'h0000_0000);
        run_op(1'b0, 32'd6, 32'd7, 10, 1'b0);
        chk("mul_6x7_lo", 64'(Z_LO), 64'd42);
        run_op(1'b0, 32'h7FFF_FFFF, MIN, 0, 1'b0);
        run_op(1'b0, $urandom, $urandom, 0, 1'b0);

        // divides
        run_op(1'b1, 32'hFFFF_FFF9, 32'd2, 0, 1'b0);
        run_op(1'b1, 32'd5, 32'd0, 0, 1'b0);
        run_op(1'b1, MIN, 32'hFFFF_FFFF, 0, 1'b0);
        run_op(1'b1, 32'd9, 32'd3, 0, 1'b0);
        run_op(1'b1, 32'd100, 32'hFFFF_FFF9, 0, 1'b0);
        run_op(1'b1, $urandom, $urandom, 0, 1'b0);

        // back-to-back: start held through the done cycle, accepted later
        run_op(1'b0, 32'd123, 32'd456, 0, 1'b1);
        run_op(1'b0, 32'hFFFF_FF00, 32'd3, 0, 1'b0);

        // clear mid-operation
        @(negedge clock);
        start = 1'b1; op = 1'b0; A = 32'd11; B = 32'd13;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (15) @(posedge clock);
        #1;
        clear = 1'b1;
        #1;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        chk("abort_zhi", 64'(Z_HI), 64'd0);
        chk("abort_zlo", 64'(Z_LO), 64'd0);
        @(negedge clock);
        clear = 1'b0;
        prev_hi = '0;
        prev_lo = '0;
        nd = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clock); #1;
            if (done) nd++;
        end
        chk("abort_no_done", 64'(nd), 64'd0);

        // recovers normally after abort
        run_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b0);
        run_op(1'b1, 32'd50, 32'd7, 0, 1'b0);

        chk("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
